// File: rtl/toggle_handshake_rx.sv
`default_nettype none
// ============================================================================
// Module      : toggle_handshake_rx
// Description : Destination-side receiver of a toggle req/ack CDC. A toggle on
//               the already-synchronized req line captures the quasi-static
//               source bus after a settle delay, offers it on a valid/ready
//               port and returns an ack toggle once the word is accepted.
//               Optional feature macro: PARITY_CHECK_EN (even-parity check
//               over {async_parity, async_data} at capture time).
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_handshake_rx #(
    parameter int DATA_WIDTH    = 8,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_WIDTH     = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync_req,
    input  logic [DATA_WIDTH-1:0] async_data,
    input  logic                  out_ready,
`ifdef PARITY_CHECK_EN
    input  logic                  async_parity,
    output logic                  parity_err,
`endif
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  ack_toggle,
    output logic                  overrun_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_VALID  = 2'd2
    } state_t;

    // Counter reload value; a zero settle delay never loads the counter.
    localparam logic [CNT_WIDTH-1:0] c_settle_load =
        CNT_WIDTH'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
    localparam bit c_no_settle = (SETTLE_CYCLES == 0);

    state_t                  r_state, w_state_nxt;
    logic                    r_req_seen, w_req_seen_nxt;
    logic [CNT_WIDTH-1:0]    r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0]   r_out_data, w_out_data_nxt;
    logic                    r_out_valid, w_out_valid_nxt;
    logic                    r_ack, w_ack_nxt;
    logic                    r_overrun, w_overrun_nxt;
    logic                    w_pending;
    logic                    w_capture;

    // A req level different from the last accepted one is a new request.
    assign w_pending = sync_req ^ r_req_seen;

    // Next-state and datapath decode; every target defaults to holding.
    always_comb begin
        w_state_nxt     = r_state;
        w_req_seen_nxt  = r_req_seen;
        w_cnt_nxt       = r_cnt;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_ack_nxt       = r_ack;
        w_overrun_nxt   = r_overrun;
        w_capture       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_pending) begin
                    w_req_seen_nxt = sync_req;
                    if (c_no_settle) begin
                        w_capture = 1'b1;
                    end else begin
                        w_cnt_nxt   = c_settle_load;
                        w_state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                // A second toggle before the ack means the source broke protocol.
                if (w_pending) begin
                    w_overrun_nxt = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_capture = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_VALID: begin
                if (w_pending) begin
                    w_overrun_nxt = 1'b1;
                end
                if (r_out_valid && out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_ack_nxt       = ~r_ack;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_capture) begin
            w_out_data_nxt  = async_data;
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = ST_VALID;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_req_seen  <= 1'b0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_ack       <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_seen  <= w_req_seen_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_ack       <= w_ack_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

`ifdef PARITY_CHECK_EN
    logic r_parity_err;

    // Single-cycle parity error flag, aligned with the rising out_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_capture & (^{async_parity, async_data});
        end
    end

    assign parity_err = r_parity_err;
`endif

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign ack_toggle  = r_ack;
    assign overrun_err = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_toggle_handshake_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_toggle_handshake_rx
// Description : Directed self-checking bench for toggle_handshake_rx with the
//               default SETTLE_CYCLES=1. Parity scenario is built only when
//               PARITY_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_toggle_handshake_rx;

    logic       clk;
    logic       reset_n;
    logic       sync_req;
    logic [7:0] async_data;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       ack_toggle;
    logic       overrun_err;
`ifdef PARITY_CHECK_EN
    logic       async_parity;
    logic       parity_err;
`endif

    int         n_tests;
    int         n_fail;
    logic       r_src_ack_s1;
    logic       r_src_ack_s2;

    toggle_handshake_rx #(
        .DATA_WIDTH    (8),
        .SETTLE_CYCLES (1),
        .CNT_WIDTH     (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sync_req     (sync_req),
        .async_data   (async_data),
        .out_ready    (out_ready),
`ifdef PARITY_CHECK_EN
        .async_parity (async_parity),
        .parity_err   (parity_err),
`endif
        .out_data     (out_data),
        .out_valid    (out_valid),
        .ack_toggle   (ack_toggle),
        .overrun_err  (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source-side 2-flop synchronizer of the returned ack.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src_ack_s1 <= 1'b0;
            r_src_ack_s2 <= 1'b0;
        end else begin
            r_src_ack_s1 <= ack_toggle;
            r_src_ack_s2 <= r_src_ack_s1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait up to a bounded number of cycles for out_valid; timeout counts as failure.
    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) break;
            tick();
        end
        check(tag, {31'd0, out_valid}, 32'd1);
    endtask

    // Wait up to a bounded number of cycles for the source to see the ack.
    task automatic wait_src_ack(input string tag, input logic lvl);
        for (int i = 0; i < 20; i++) begin
            if (r_src_ack_s2 === lvl) break;
            tick();
        end
        check(tag, {31'd0, r_src_ack_s2}, {31'd0, lvl});
    endtask

    logic [7:0] words [3];

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        sync_req   = 1'b0;
        async_data = 8'h00;
        out_ready  = 1'b0;
`ifdef PARITY_CHECK_EN
        async_parity = 1'b0;
`endif
        words[0] = 8'h01;
        words[1] = 8'h02;
        words[2] = 8'h03;

        // 1: reset then idle
        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'h00);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("idle_valid", {31'd0, out_valid}, 32'd0);
        check("idle_ack", {31'd0, ack_toggle}, 32'd0);
        check("idle_ovr", {31'd0, overrun_err}, 32'd0);

        // 2: single word, ready held high, latency t+2 valid, t+3 ack
        out_ready  = 1'b1;
        async_data = 8'hA5;
        sync_req   = 1'b1;
        tick();
        check("t2_valid_t1", {31'd0, out_valid}, 32'd0);
        tick();
        check("t2_valid_t2", {31'd0, out_valid}, 32'd1);
        check("t2_data", {24'd0, out_data}, 32'hA5);
        check("t2_ack_t2", {31'd0, ack_toggle}, 32'd0);
        tick();
        check("t2_valid_t3", {31'd0, out_valid}, 32'd0);
        check("t2_ack_t3", {31'd0, ack_toggle}, 32'd1);

        // 3: backpressure with data changing during VALID
        out_ready = 1'b0;
        sync_req  = 1'b0;
        tick();
        tick();
        check("t3_valid", {31'd0, out_valid}, 32'd1);
        async_data = 8'h00;
        for (int i = 0; i < 5; i++) tick();
        check("t3_hold_data", {24'd0, out_data}, 32'hA5);
        check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
        check("t3_hold_ack", {31'd0, ack_toggle}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("t3_done_valid", {31'd0, out_valid}, 32'd0);
        check("t3_done_ack", {31'd0, ack_toggle}, 32'd0);
        tick();
        check("t3_single_flip", {31'd0, ack_toggle}, 32'd0);

        // 4: three ordered words with a modelled 2-flop ack return
        wait_src_ack("t4_src_ack0", 1'b0);
        for (int w = 0; w < 3; w++) begin
            async_data = words[w];
            sync_req   = ~sync_req;
            tick();
            wait_valid("t4_valid");
            check("t4_data", {24'd0, out_data}, {24'd0, words[w]});
            tick();
            check("t4_ack", {31'd0, ack_toggle}, (w % 2 == 0) ? 32'd1 : 32'd0);
            wait_src_ack("t4_src_ack", sync_req);
        end
        check("t4_ovr", {31'd0, overrun_err}, 32'd0);

        // 5: second toggle while VALID
        out_ready  = 1'b0;
        async_data = 8'h11;
        sync_req   = ~sync_req;
        tick();
        tick();
        check("t5_valid", {31'd0, out_valid}, 32'd1);
        check("t5_ovr_before", {31'd0, overrun_err}, 32'd0);
        async_data = 8'h22;
        sync_req   = ~sync_req;
        tick();
        check("t5_ovr_set", {31'd0, overrun_err}, 32'd1);
        check("t5_data_first", {24'd0, out_data}, 32'h11);
        out_ready = 1'b1;
        tick();
        check("t5_hs_valid", {31'd0, out_valid}, 32'd0);
        check("t5_hs_ack", {31'd0, ack_toggle}, 32'd0);
        tick();
        check("t5_settle_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("t5_second_valid", {31'd0, out_valid}, 32'd1);
        check("t5_second_data", {24'd0, out_data}, 32'h22);
        tick();
        check("t5_second_ack", {31'd0, ack_toggle}, 32'd1);
        check("t5_ovr_sticky", {31'd0, overrun_err}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_ovr", {31'd0, overrun_err}, 32'd0);
        check("t5_rst_ack", {31'd0, ack_toggle}, 32'd0);
        sync_req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

`ifdef PARITY_CHECK_EN
        // 6: parity mismatch pulse aligned with out_valid rise
        out_ready    = 1'b0;
        async_data   = 8'h03;
        async_parity = 1'b1;
        sync_req     = 1'b1;
        tick();
        check("t6_perr_settle", {31'd0, parity_err}, 32'd0);
        tick();
        check("t6_valid", {31'd0, out_valid}, 32'd1);
        check("t6_perr_pulse", {31'd0, parity_err}, 32'd1);
        tick();
        check("t6_perr_clear", {31'd0, parity_err}, 32'd0);
        out_ready = 1'b1;
        tick();
        async_parity = 1'b0;
        sync_req     = 1'b0;
        tick();
        tick();
        check("t6_valid_ok", {31'd0, out_valid}, 32'd1);
        check("t6_perr_ok", {31'd0, parity_err}, 32'd0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
